// File: rtl/mdu_core_if.sv
// rtl/mdu_core_if.sv - E-stage multiply/divide unit handshake and HI/LO bus
interface mdu_core_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  // Pipeline side: issues operations, observes Busy and HI/LO
  modport master (output Start, Op, A, B, input Busy, HI, LO);
  // Unit side
  modport slave  (input Start, Op, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - multi-cycle mult/div unit owning the HI/LO registers
module mdu_core #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_core_if.slave  bus
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  // Cleared for divide-by-zero so the completion edge leaves HI/LO alone
  logic          pwr_q, pwr_d;

  logic [63:0]   prod_s, prod_u;
  logic [31:0]   dvs, quot_s, rem_s, quot_u, rem_u;
  logic          is_md, is_div, div_zero;

  // Datapath: results are computed from operands present at the start edge
  always_comb begin
    prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    div_zero = (bus.B == 32'd0);
    // Substitute divisor keeps the divider defined; its result is discarded
    dvs = div_zero ? 32'd1 : bus.B;
    if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'd0;
    end else begin
      quot_s = $signed(bus.A) / $signed(dvs);
      rem_s  = $signed(bus.A) % $signed(dvs);
    end
    quot_u = bus.A / dvs;
    rem_u  = bus.A % dvs;
    is_md  = (bus.Op >= OP_MULT) && (bus.Op <= OP_DIVU);
    is_div = (bus.Op == OP_DIV) || (bus.Op == OP_DIVU);
  end

  // Next-state: accept in IDLE, count down in RUN, commit on the last cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    case (state_q)
      IDLE: begin
        if (bus.Start && is_md) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          pwr_d   = !(is_div && div_zero);
          case (bus.Op)
            OP_MULT:  begin phi_d = prod_s[63:32]; plo_d = prod_s[31:0]; end
            OP_MULTU: begin phi_d = prod_u[63:32]; plo_d = prod_u[31:0]; end
            OP_DIV:   begin phi_d = rem_s;         plo_d = quot_s;       end
            default:  begin phi_d = rem_u;         plo_d = quot_u;       end
          endcase
        end else if (!bus.Start && bus.Op == OP_MTHI) begin
          hi_d = bus.A;
        end else if (!bus.Start && bus.Op == OP_MTLO) begin
          lo_d = bus.A;
        end
      end
      default: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_core.sv
// tb/tb_mdu_core.sv - directed scoreboard bench for the multiply/divide unit
module tb_mdu_core;
  localparam int MC = 5;
  localparam int DC = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  res_t sb[$];
  res_t exp_r;
  logic [31:0] cur_hi, cur_lo;

  mdu_core_if bus ();

  mdu_core #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one md op, check Busy for exactly n cycles with HI/LO frozen,
  // then pop the expected result and compare at the completion edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] ehi,
                        input logic [31:0] elo, input bit inject);
    sb.push_back('{hi: ehi, lo: elo});
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    tick();
    bus.Start = 1'b0; bus.Op = 3'd0;
    bus.A = $urandom; bus.B = $urandom;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'd0, bus.Busy}, 32'd1);
      chk({tag, "_hi_hold"}, bus.HI, cur_hi);
      chk({tag, "_lo_hold"}, bus.LO, cur_lo);
      bus.Start = 1'b0; bus.Op = 3'd0;
      if (inject && i == 2) begin
        bus.Start = 1'b1; bus.Op = 3'd1; bus.A = 32'd9; bus.B = 32'd9;
      end
      if (inject && i == 5) begin
        bus.Op = 3'd6; bus.A = 32'hDEAD_BEEF;
      end
      if (i < n - 1) tick();
    end
    bus.Start = 1'b0; bus.Op = 3'd0;
    tick();
    chk({tag, "_busy_fall"}, {31'd0, bus.Busy}, 32'd0);
    exp_r = sb.pop_front();
    chk({tag, "_hi"}, bus.HI, exp_r.hi);
    chk({tag, "_lo"}, bus.LO, exp_r.lo);
    cur_hi = exp_r.hi;
    cur_lo = exp_r.lo;
  endtask

  initial begin
    bus.Start = 1'b0; bus.Op = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);

    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu", 3'd4, 32'hFFFF_FFF9, 32'd2, DC, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // mthi then mtlo on consecutive idle cycles
    bus.Op = 3'd5; bus.A = 32'h1234_5678;
    tick();
    chk("mthi_hi", bus.HI, 32'h1234_5678);
    chk("mthi_busy", {31'd0, bus.Busy}, 32'd0);
    bus.Op = 3'd6; bus.A = 32'h9ABC_DEF0;
    tick();
    chk("mtlo_lo", bus.LO, 32'h9ABC_DEF0);
    chk("mtlo_hi", bus.HI, 32'h1234_5678);
    chk("mtlo_busy", {31'd0, bus.Busy}, 32'd0);
    cur_hi = 32'h1234_5678;
    cur_lo = 32'h9ABC_DEF0;

    run_op("div0", 3'd3, 32'd77, 32'd0, DC, cur_hi, cur_lo, 1'b0);
    run_op("divu0", 3'd4, 32'd77, 32'd0, DC, cur_hi, cur_lo, 1'b0);

    // No-op encodings: Start with non-md op, md op without Start
    bus.Start = 1'b1; bus.Op = 3'd7; bus.A = 32'h5555_5555;
    tick();
    chk("noop7_busy", {31'd0, bus.Busy}, 32'd0);
    bus.Op = 3'd5;
    tick();
    chk("start_mthi_hi", bus.HI, cur_hi);
    bus.Start = 1'b0; bus.Op = 3'd1; bus.A = 32'd4; bus.B = 32'd4;
    tick();
    chk("nostart_busy", {31'd0, bus.Busy}, 32'd0);
    chk("nostart_lo", bus.LO, cur_lo);
    bus.Op = 3'd0;

    // Reset mid-divide, then a mult right after
    bus.Start = 1'b1; bus.Op = 3'd3; bus.A = 32'd1000; bus.B = 32'd3;
    tick();
    bus.Start = 1'b0; bus.Op = 3'd0;
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_busy", {31'd0, bus.Busy}, 32'd1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_busy0", {31'd0, bus.Busy}, 32'd0);
    chk("rstmid_hi", bus.HI, 32'd0);
    chk("rstmid_lo", bus.LO, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    run_op("mult_after_rst", 3'd1, 32'd100, 32'hFFFF_FFF6, MC, 32'hFFFF_FFFF, 32'hFFFF_FC18, 1'b0);
    for (int i = 0; i < DC; i++) tick();
    chk("no_late_hi", bus.HI, cur_hi);
    chk("no_late_lo", bus.LO, cur_lo);

    // Start and mtlo injected during a divide must be ignored
    run_op("div_inject", 3'd3, 32'd100, 32'd7, DC, 32'd2, 32'd14, 1'b1);
    tick();
    chk("inject_after_busy", {31'd0, bus.Busy}, 32'd0);
    chk("inject_after_lo", bus.LO, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mdu_core.md
Name: mdu_core

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes mult, multu, div and divu over multiple cycles.
- Drives the Busy flag that the hazard unit combines with Start. The hazard unit stalls any md/mf/mt instruction in D while Start or Busy is high.
- Handles mthi/mtlo writes in one cycle and exposes HI/LO for mfhi/mflo selection in E.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu (>=1)
- DIV_CYCLES, 10, number of cycles Busy stays high for div/divu (>=1)

Ports:
- clk    input   1   system clock, all state on rising edge
- reset  input   1   synchronous, active-high; clears all state
- Start  input   1   E-stage instruction is mult/multu/div/divu; qualifies Op
- Op     input   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op)
- A      input   32  rs operand, already forwarded
- B      input   32  rt operand, already forwarded
- Busy   output  1   operation in flight
- HI     output  32  current HI register
- LO     output  32  current LO register

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: Busy=0, HI=0, LO=0, internal counter=0, pending result registers=0.
- Reset has priority over every other input in the same cycle.
- States:
  - IDLE (counter==0, Busy=0)
  - RUN (counter>0, Busy=1)
- IDLE -> RUN:
  - Taken at an edge where Start=1, Op in {1..4}, Busy=0.
  - Counter loads MULT_CYCLES (Op 1,2) or DIV_CYCLES (Op 3,4).
  - Result is computed from A/B sampled at that edge and held in pending HI/LO registers.
  - A/B changes after the start edge have no effect.
- RUN: counter decrements each edge. At the edge where counter goes 1->0:
  - HI/LO take the pending values.
  - Busy falls.
  - State returns to IDLE.
- Latency: Start sampled at edge k gives Busy=1 for cycles k+1 .. k+N exactly (N = cycle parameter). HI/LO hold new values from edge k+N. Busy is registered, never combinational from Start.
- Arithmetic:
  - mult: {HI,LO} = signed(A) * signed(B), 64-bit.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient, truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (B==0, div or divu): the operation still runs DIV_CYCLES with Busy high. HI/LO are left unchanged at completion.
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- mthi/mtlo:
  - Written at the next edge when Op=5/6 with Busy=0 and Start=0: HI=A or LO=A.
  - Busy is not asserted.
  - Ignored while Busy=1 (the hazard unit prevents this case; ignoring it keeps the design safe).
- Start=1 while Busy=1: ignored. The in-flight operation completes unaffected.
- Start=1 with Op not in {1..4}: treated as no-op; no state change.
- Start=0 with Op in {1..4}: no-op.
- Reset mid-operation: at the reset edge Busy=0, HI=LO=0, pending result discarded. The next Start after reset is accepted normally.
- Back-to-back operations: a Start sampled on the first cycle with Busy=0 after completion is accepted. HI/LO show the previous result until the new completion edge.
- HI/LO outputs are stable during RUN (old values visible to nothing, since mf is stalled).

Test Plan:
- Reset, then mult A=0xFFFFFFFE (-2), B=3, Start at edge 0 -> Busy=1 for cycles 1-5, falls at edge 5; HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO=0 before edge 5.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu on same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive idle cycles -> HI/LO updated one edge each, Busy stays 0. Then div with B=0 -> Busy 10 cycles, HI/LO unchanged.
- Start div and pulse reset at cycle 4 -> Busy=0, HI=LO=0 at the reset edge, no later commit. Start mult next cycle -> accepted, normal 5-cycle completion.
- During a div, assert Start with a mult at cycle 3 and mtlo at cycle 6 -> both ignored; div result commits at cycle 10, Busy pattern unchanged.
